vga_layer_arbiter: RTL
======================

// Module: vga_layer_arbiter
// PURPOSE
//  Per-pixel compositor and scheduler feeding rgbContent of the VGA timing block.
//  Gives NUM_LAYERS pixel requesters (board, pieces, cursor, text) lookahead
//  coordinates one pixel ahead, grants the highest-priority opaque layer and
//  registers its colour. A handshaked config port sets layer enables, blink mask
//  and background colour; updates are double-buffered and applied only at frame boundaries.
// PARAMETERS
//  NUM_LAYERS    4    requester count; index 0 = highest priority
//  H_TOTAL       800  pixel clocks per line (horCnt wraps H_TOTAL-1 -> 0)
//  V_TOTAL       525  lines per frame (verCnt wraps V_TOTAL-1 -> 0)
//  H_ACTIVE      640  visible pixels per line
//  V_ACTIVE      480  visible lines per frame
//  BLINK_FRAMES  30   frames per blink half-period
// PORTS
//  clk          in   1             pixel clock, same clock as the VGA counters
//  resetN       in   1             asynchronous, active-low reset
//  horCnt       in   10            horizontal counter from the timing block
//  verCnt       in   10            vertical counter from the timing block
//  lookX        out  10            lookahead column for the layers (combinational)
//  lookY        out  10            lookahead row for the layers (combinational)
//  layerReq     in   NUM_LAYERS    layer i is opaque at (lookX,lookY)
//  layerColour  in   6*NUM_LAYERS  layer i colour at [6i+5:6i], {B,G,R} 2 bits each
//  cfgValid     in   1             config word valid
//  cfgReady     out  1             pending slot free
//  cfgEnable    in   NUM_LAYERS    layer enable mask
//  cfgBlink     in   NUM_LAYERS    layers hidden during the blink-off phase
//  cfgBgColour  in   6             colour where no layer is granted
//  rgbContent   out  6             registered pixel colour for the current horCnt/verCnt
//  grantIdx     out  clog2(NUM_LAYERS)  registered winning layer index
//  grantValid   out  1             a layer won this pixel
//  frameStart   out  1             one-cycle pulse at horCnt==0 && verCnt==0
//  vblank       out  1             FSM is in VBLANK
// BEHAVIOUR
//  Reset (async assert, sync release): rgbContent=0, grantIdx=0, grantValid=0,
//   frameStart=0, vblank=0, state=SCAN, blink counter=0, blinkPhase=0,
//   active cfg={enable=all 1, blink=0, bg=0}, pending empty, cfgReady=1.
//  Lookahead: lookX = (horCnt==H_TOTAL-1) ? 0 : horCnt+1.
//   lookY = verCnt, except when horCnt==H_TOTAL-1: (verCnt==V_TOTAL-1) ? 0 : verCnt+1.
//  Pixel pipe (latency 1): sample on the clock edge while lookX/lookY are driven.
//   If lookX<H_ACTIVE and lookY<V_ACTIVE: eligible[i] = layerReq[i] & enable[i]
//    & ~(blink[i] & blinkPhase). The winner is the lowest eligible index:
//    rgbContent = its colour, grantValid=1. With no eligible layer:
//    rgbContent = bg, grantValid=0, grantIdx holds its previous value.
//   Otherwise rgbContent=0, grantValid=0. Net pixel shift on screen is zero.
//  FSM SCAN <-> VBLANK, evaluated every cycle:
//   SCAN -> VBLANK when horCnt==H_TOTAL-1 and verCnt==V_ACTIVE-1.
//   VBLANK -> SCAN when horCnt==H_TOTAL-1 and verCnt==V_TOTAL-1.
//   frameStart is registered: high for the one cycle where horCnt==0 && verCnt==0.
//  Boundary = cycle of the SCAN->VBLANK transition.
//   If pending is full, active cfg<=pending and pending empties.
//   The blink counter increments; at BLINK_FRAMES-1 it wraps to 0 and toggles blinkPhase.
//  Config handshake: accept when cfgValid & cfgReady; cfgReady = ~pendingFull.
//   An accept writes pending. An accept on the boundary cycle with pending empty
//   stays pending and applies at the next boundary. Active cfg never changes mid-frame.
//   cfgValid held with cfgReady=0 is not consumed.
//  Mid-frame reset: outputs clear immediately. On the first clock after release the
//   state is re-derived: VBLANK if verCnt>=V_ACTIVE, else SCAN.
//   A pending update is lost.
// STRUCTURE
//  vga_pkg: H_/V_ TOTAL/ACTIVE constants, COLOUR_W=6, state encoding (SCAN, VBLANK).
//  Sub-module layer_priority_mux: combinational eligible-mask -> {found, idx, colour}.
//  Top holds the lookahead, FSM, config double-buffer, blink counter and output registers.
// TESTING
//  1 Reset mid-line at horCnt=300, verCnt=100 -> all outputs 0 and cfgReady=1;
//    after release, vblank=0 and enable=4'b1111.
//  2 layerReq=4'b0110, colours L1=6'h0C, L2=6'h30, at lookX=5 -> next cycle
//    rgbContent=6'h0C, grantIdx=1, grantValid=1.
//  3 layerReq=0, bg=6'h15, at horCnt=639 (lookX=640) -> next cycle rgbContent=0;
//    with horCnt=638 -> next cycle 6'h15.
//  4 Write cfg enable=4'b1101 at verCnt=200 -> cfgReady=0, L1 still wins until the
//    boundary (799,479); from verCnt=0 L1 is ignored and cfgReady=1.
//  5 cfgBlink=4'b0001, only L0 opaque -> L0 shown for 30 frames, bg for 30, L0 again.
//  6 Wrap check: horCnt=799, verCnt=524 -> lookX=0, lookY=0; frameStart pulses the next cycle.

Source files
------------

// File: rtl/vga_layer_arbiter_pkg.sv
// Shared constants and state encoding for the VGA layer arbiter.
package vga_layer_arbiter_pkg;

  localparam int unsigned NUM_LAYERS_DEF   = 4;
  localparam int unsigned H_TOTAL_DEF      = 800;
  localparam int unsigned V_TOTAL_DEF      = 525;
  localparam int unsigned H_ACTIVE_DEF     = 640;
  localparam int unsigned V_ACTIVE_DEF     = 480;
  localparam int unsigned BLINK_FRAMES_DEF = 30;
  localparam int unsigned COLOUR_W         = 6;
  localparam int unsigned CNT_W            = 10;

  typedef enum logic {
    SCAN   = 1'b0,
    VBLANK = 1'b1
  } state_e;

endpackage

// File: rtl/vga_layer_arbiter_layer_priority_mux.sv
// Combinational priority select: the lowest eligible layer index wins.
module layer_priority_mux
  import vga_layer_arbiter_pkg::*;
#(
  parameter int unsigned NUM_LAYERS = NUM_LAYERS_DEF,
  parameter int unsigned IDX_W      = (NUM_LAYERS > 1) ? $clog2(NUM_LAYERS) : 1
) (
  input  logic [NUM_LAYERS-1:0]          eligible,
  input  logic [COLOUR_W*NUM_LAYERS-1:0] colours,
  output logic                           found_c,
  output logic [IDX_W-1:0]               idx_c,
  output logic [COLOUR_W-1:0]            colour_c
);

  // Walk from the lowest priority upward so the last hit is the winner.
  always_comb begin
    found_c  = 1'b0;
    idx_c    = '0;
    colour_c = '0;
    for (int i = int'(NUM_LAYERS) - 1; i >= 0; i--) begin
      if (eligible[i]) begin
        found_c  = 1'b1;
        idx_c    = IDX_W'(i);
        colour_c = colours[COLOUR_W*i +: COLOUR_W];
      end
    end
  end

endmodule

// File: rtl/vga_layer_arbiter.sv
// Per-pixel layer compositor: lookahead coordinates, priority grant, blink and
// frame-synchronous double-buffered configuration.
module vga_layer_arbiter
  import vga_layer_arbiter_pkg::*;
#(
  parameter int unsigned NUM_LAYERS   = NUM_LAYERS_DEF,
  parameter int unsigned H_TOTAL      = H_TOTAL_DEF,
  parameter int unsigned V_TOTAL      = V_TOTAL_DEF,
  parameter int unsigned H_ACTIVE     = H_ACTIVE_DEF,
  parameter int unsigned V_ACTIVE     = V_ACTIVE_DEF,
  parameter int unsigned BLINK_FRAMES = BLINK_FRAMES_DEF,
  parameter int unsigned IDX_W        = (NUM_LAYERS > 1) ? $clog2(NUM_LAYERS) : 1
) (
  input  logic                           clk,
  input  logic                           resetN,
  input  logic [CNT_W-1:0]               horCnt,
  input  logic [CNT_W-1:0]               verCnt,
  output logic [CNT_W-1:0]               lookX,
  output logic [CNT_W-1:0]               lookY,
  input  logic [NUM_LAYERS-1:0]          layerReq,
  input  logic [COLOUR_W*NUM_LAYERS-1:0] layerColour,
  input  logic                           cfgValid,
  output logic                           cfgReady,
  input  logic [NUM_LAYERS-1:0]          cfgEnable,
  input  logic [NUM_LAYERS-1:0]          cfgBlink,
  input  logic [COLOUR_W-1:0]            cfgBgColour,
  output logic [COLOUR_W-1:0]            rgbContent,
  output logic [IDX_W-1:0]               grantIdx,
  output logic                           grantValid,
  output logic                           frameStart,
  output logic                           vblank
);

  localparam int unsigned BLINK_W = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;

  state_e                  state_q, state_d, state_cur;
  logic                    init_q, init_d;
  logic [BLINK_W-1:0]      blink_cnt_q, blink_cnt_d;
  logic                    blink_phase_q, blink_phase_d;
  logic [NUM_LAYERS-1:0]   act_en_q, act_en_d, act_bl_q, act_bl_d;
  logic [COLOUR_W-1:0]     act_bg_q, act_bg_d;
  logic [NUM_LAYERS-1:0]   pend_en_q, pend_en_d, pend_bl_q, pend_bl_d;
  logic [COLOUR_W-1:0]     pend_bg_q, pend_bg_d;
  logic                    pend_full_q, pend_full_d;
  logic [COLOUR_W-1:0]     rgb_q, rgb_d;
  logic [IDX_W-1:0]        idx_q, idx_d;
  logic                    gv_q, gv_d;
  logic                    fs_q, fs_d;

  logic                    eol, boundary, accept, in_active;
  logic [NUM_LAYERS-1:0]   eligible;
  logic                    mux_found;
  logic [IDX_W-1:0]        mux_idx;
  logic [COLOUR_W-1:0]     mux_colour;

  // Lookahead: the layers see the pixel that will be on screen next cycle.
  always_comb begin
    eol   = (horCnt == CNT_W'(H_TOTAL - 1));
    lookX = eol ? '0 : horCnt + CNT_W'(1);
    lookY = verCnt;
    if (eol) begin
      lookY = (verCnt == CNT_W'(V_TOTAL - 1)) ? '0 : verCnt + CNT_W'(1);
    end
  end

  assign eligible = layerReq & act_en_q & ~(act_bl_q & {NUM_LAYERS{blink_phase_q}});

  layer_priority_mux #(
    .NUM_LAYERS (NUM_LAYERS),
    .IDX_W      (IDX_W)
  ) u_mux (
    .eligible (eligible),
    .colours  (layerColour),
    .found_c  (mux_found),
    .idx_c    (mux_idx),
    .colour_c (mux_colour)
  );

  // After reset the state is unknown relative to the counters, so re-derive it once.
  always_comb begin
    state_cur = init_q ? ((verCnt >= CNT_W'(V_ACTIVE)) ? VBLANK : SCAN) : state_q;
    state_d   = state_cur;
    init_d    = 1'b0;
    boundary  = 1'b0;
    case (state_cur)
      SCAN: begin
        if (eol && verCnt == CNT_W'(V_ACTIVE - 1)) begin
          state_d  = VBLANK;
          boundary = 1'b1;
        end
      end
      VBLANK: begin
        if (eol && verCnt == CNT_W'(V_TOTAL - 1)) begin
          state_d = SCAN;
        end
      end
    endcase
  end

  // Config double-buffer and blink counter, both advanced on the frame boundary.
  always_comb begin
    accept        = cfgValid & ~pend_full_q;
    act_en_d      = act_en_q;
    act_bl_d      = act_bl_q;
    act_bg_d      = act_bg_q;
    pend_en_d     = pend_en_q;
    pend_bl_d     = pend_bl_q;
    pend_bg_d     = pend_bg_q;
    pend_full_d   = pend_full_q;
    blink_cnt_d   = blink_cnt_q;
    blink_phase_d = blink_phase_q;
    if (boundary) begin
      if (pend_full_q) begin
        act_en_d    = pend_en_q;
        act_bl_d    = pend_bl_q;
        act_bg_d    = pend_bg_q;
        pend_full_d = 1'b0;
      end
      if (blink_cnt_q == BLINK_W'(BLINK_FRAMES - 1)) begin
        blink_cnt_d   = '0;
        blink_phase_d = ~blink_phase_q;
      end else begin
        blink_cnt_d = blink_cnt_q + BLINK_W'(1);
      end
    end
    if (accept) begin
      pend_en_d   = cfgEnable;
      pend_bl_d   = cfgBlink;
      pend_bg_d   = cfgBgColour;
      pend_full_d = 1'b1;
    end
  end

  // Pixel pipe: grantIdx holds whenever no layer wins.
  always_comb begin
    in_active = (lookX < CNT_W'(H_ACTIVE)) && (lookY < CNT_W'(V_ACTIVE));
    rgb_d     = '0;
    gv_d      = 1'b0;
    idx_d     = idx_q;
    fs_d      = (lookX == '0) && (lookY == '0);
    if (in_active) begin
      if (mux_found) begin
        rgb_d = mux_colour;
        gv_d  = 1'b1;
        idx_d = mux_idx;
      end else begin
        rgb_d = act_bg_q;
      end
    end
  end

  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      state_q       <= SCAN;
      init_q        <= 1'b1;
      blink_cnt_q   <= '0;
      blink_phase_q <= 1'b0;
      act_en_q      <= '1;
      act_bl_q      <= '0;
      act_bg_q      <= '0;
      pend_en_q     <= '0;
      pend_bl_q     <= '0;
      pend_bg_q     <= '0;
      pend_full_q   <= 1'b0;
      rgb_q         <= '0;
      idx_q         <= '0;
      gv_q          <= 1'b0;
      fs_q          <= 1'b0;
    end else begin
      state_q       <= state_d;
      init_q        <= init_d;
      blink_cnt_q   <= blink_cnt_d;
      blink_phase_q <= blink_phase_d;
      act_en_q      <= act_en_d;
      act_bl_q      <= act_bl_d;
      act_bg_q      <= act_bg_d;
      pend_en_q     <= pend_en_d;
      pend_bl_q     <= pend_bl_d;
      pend_bg_q     <= pend_bg_d;
      pend_full_q   <= pend_full_d;
      rgb_q         <= rgb_d;
      idx_q         <= idx_d;
      gv_q          <= gv_d;
      fs_q          <= fs_d;
    end
  end

  assign cfgReady   = ~pend_full_q;
  assign rgbContent = rgb_q;
  assign grantIdx   = idx_q;
  assign grantValid = gv_q;
  assign frameStart = fs_q;
  assign vblank     = (state_q == VBLANK);

endmodule
